// File: rtl/led_pattern_driver_if.sv
// Control/status bundle between the LED driver and whoever sets its mode and brightness.
interface led_pattern_driver_if;
    logic [1:0] mode_sel;
    logic       mode_load;
    logic [7:0] brightness;
    logic [3:0] led;
    logic       step_tick;
    logic [1:0] mode;

    // Controller side: issues mode/brightness, observes the pins and status.
    modport master (
        output mode_sel,
        output mode_load,
        output brightness,
        input  led,
        input  step_tick,
        input  mode
    );

    // Driver side.
    modport slave (
        input  mode_sel,
        input  mode_load,
        input  brightness,
        output led,
        output step_tick,
        output mode
    );
endinterface

// File: rtl/led_pattern_driver.sv
// LED output stage for a 4-LED bank: tick prescaler, step counter, pattern sequencer
// (OFF/BLINK/CHASE/BREATHE) and 8-bit PWM dimming, all on the single osc_clk domain.
module led_pattern_driver #(
    parameter int unsigned TICK_DIV    = 450000,
    parameter int unsigned STEP_TICKS  = 250,
    parameter int unsigned BREATHE_INC = 1
) (
    input logic                 osc_clk,
    input logic                 gsrn,
    led_pattern_driver_if.slave bus
);

    localparam int unsigned PRESC_W = $clog2(TICK_DIV);
    localparam int unsigned STEP_W  = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
    localparam logic [STEP_W-1:0]  STEP_MAX  = STEP_W'(STEP_TICKS - 1);
    localparam logic [8:0]         INC       = 9'(BREATHE_INC);

    typedef enum logic [1:0] {
        ModeOff     = 2'd0,
        ModeBlink   = 2'd1,
        ModeChase   = 2'd2,
        ModeBreathe = 2'd3
    } mode_e;

    mode_e              mode_q, mode_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
    logic [7:0]         pwm_cnt_q;
    logic [3:0]         pattern_q, pattern_d;
    logic [7:0]         level_q, level_d;
    logic               dir_up_q, dir_up_d;
    logic [3:0]         led_q, led_d;
    logic               step_tick_q;

    logic       tick;
    logic       step;
    logic [7:0] duty;
    logic       pwm_on;
    logic [8:0] up_sum;
    logic [8:0] dn_diff;

    assign tick = (presc_q == PRESC_MAX);
    assign step = tick && (step_cnt_q == STEP_MAX);

    // Mode state register.
    always_ff @(posedge osc_clk or negedge gsrn) begin
        if (!gsrn) begin
            mode_q <= ModeBlink;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode next state: a load always commits, even if it re-selects the current mode.
    always_comb begin
        mode_d = mode_q;
        if (bus.mode_load) begin
            mode_d = mode_e'(bus.mode_sel);
        end
    end

    // Pattern next value: load restarts at the entry pattern and swallows a coincident step.
    always_comb begin
        pattern_d = pattern_q;
        if (bus.mode_load) begin
            case (mode_e'(bus.mode_sel))
                ModeChase:   pattern_d = 4'b0001;
                ModeBreathe: pattern_d = 4'b1111;
                default:     pattern_d = 4'b0000;
            endcase
        end else begin
            case (mode_q)
                ModeOff:     pattern_d = 4'b0000;
                ModeBlink:   pattern_d = step ? {4{~pattern_q[0]}} : pattern_q;
                ModeChase:   pattern_d = step ? {pattern_q[2:0], pattern_q[3]} : pattern_q;
                ModeBreathe: pattern_d = 4'b1111;
                default:     pattern_d = 4'b0000;
            endcase
        end
    end

    // Prescaler and step counter next values; a load restarts both from zero.
    always_comb begin
        presc_d    = presc_q + PRESC_W'(1);
        step_cnt_d = step_cnt_q;
        if (tick) begin
            presc_d    = '0;
            step_cnt_d = step ? '0 : step_cnt_q + STEP_W'(1);
        end
        if (bus.mode_load) begin
            presc_d    = '0;
            step_cnt_d = '0;
        end
    end

    // Breathe level: 9-bit arithmetic so the saturation checks see any overflow/underflow.
    always_comb begin
        up_sum   = {1'b0, level_q} + INC;
        dn_diff  = {1'b0, level_q} - INC;
        level_d  = level_q;
        dir_up_d = dir_up_q;
        if (bus.mode_load) begin
            level_d  = 8'd0;
            dir_up_d = 1'b1;
        end else if (mode_q == ModeBreathe && tick) begin
            if (dir_up_q) begin
                if (up_sum >= 9'd255) begin
                    level_d  = 8'd255;
                    dir_up_d = 1'b0;
                end else begin
                    level_d = up_sum[7:0];
                end
            end else begin
                if (dn_diff[8] || dn_diff == 9'd0) begin
                    level_d  = 8'd0;
                    dir_up_d = 1'b1;
                end else begin
                    level_d = dn_diff[7:0];
                end
            end
        end
    end

    // PWM gate: full scale is forced on so 255 really means continuously lit.
    always_comb begin
        duty   = (mode_q == ModeBreathe) ? level_q : bus.brightness;
        pwm_on = (duty == 8'hFF) || (pwm_cnt_q < duty);
        led_d  = pattern_q & {4{pwm_on}};
    end

    // Datapath registers.
    always_ff @(posedge osc_clk or negedge gsrn) begin
        if (!gsrn) begin
            presc_q     <= '0;
            step_cnt_q  <= '0;
            pwm_cnt_q   <= 8'd0;
            pattern_q   <= 4'b0000;
            level_q     <= 8'd0;
            dir_up_q    <= 1'b1;
            led_q       <= 4'b0000;
            step_tick_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            step_cnt_q  <= step_cnt_d;
            pwm_cnt_q   <= pwm_cnt_q + 8'd1;
            pattern_q   <= pattern_d;
            level_q     <= level_d;
            dir_up_q    <= dir_up_d;
            led_q       <= led_d;
            step_tick_q <= step && !bus.mode_load;
        end
    end

    assign bus.led       = led_q;
    assign bus.step_tick = step_tick_q;
    assign bus.mode      = mode_q;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Directed bench for led_pattern_driver with TICK_DIV=4, STEP_TICKS=3, BREATHE_INC=64
// (one step every 12 cycles, one breathe move every 4 cycles).
module tb_led_pattern_driver;

    logic osc_clk = 1'b0;
    logic gsrn;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Breathe duty after each successive tick following a load.
    int unsigned seq [10] = '{0, 64, 128, 192, 255, 191, 127, 63, 0, 64};

    led_pattern_driver_if bus ();

    led_pattern_driver #(
        .TICK_DIV    (4),
        .STEP_TICKS  (3),
        .BREATHE_INC (64)
    ) dut (
        .osc_clk (osc_clk),
        .gsrn    (gsrn),
        .bus     (bus)
    );

    always #5 osc_clk = ~osc_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit after it.
    task automatic clk_step();
        @(posedge osc_clk);
        #1;
    endtask

    // Expected led in BREATHE at edge n, load committed at edge e, pwm_cnt = edges since reset.
    function automatic logic [3:0] breathe_exp(input int n, input int e);
        int unsigned d;
        int unsigned pwm;
        d   = seq[(n - 1 - e) / 4];
        pwm = (n - 1) % 256;
        return ((d == 255) || (pwm < d)) ? 4'hF : 4'h0;
    endfunction

    initial begin
        logic [3:0] exp_led;
        int         on_cnt [4];
        int         uneq_cnt;
        int         lit_cnt;

        gsrn           = 1'b0;
        bus.mode_sel   = 2'd0;
        bus.mode_load  = 1'b0;
        bus.brightness = 8'd255;
        repeat (3) clk_step();

        // Reset state.
        check_eq("rst_led", bus.led, 4'h0);
        check_eq("rst_step_tick", bus.step_tick, 1'b0);
        check_eq("rst_mode", bus.mode, 2'd1);

        // BLINK out of reset at full brightness: step every 12 edges, led one edge later.
        gsrn = 1'b1;
        for (int n = 1; n <= 59; n++) begin
            clk_step();
            exp_led = (n >= 13 && ((n - 1) / 12) % 2 == 1) ? 4'hF : 4'h0;
            check_eq($sformatf("blink_led_%0d", n), bus.led, exp_led);
            check_eq($sformatf("blink_st_%0d", n), bus.step_tick, (n % 12) == 0);
        end

        // Load on the very cycle of a step (edge 60): the toggle to 1111 must be discarded.
        bus.mode_sel  = 2'd1;
        bus.mode_load = 1'b1;
        for (int n = 60; n <= 73; n++) begin
            clk_step();
            bus.mode_load = 1'b0;
            check_eq($sformatf("coll_led_%0d", n), bus.led, (n == 73) ? 4'hF : 4'h0);
            check_eq($sformatf("coll_st_%0d", n), bus.step_tick, n == 72);
        end
        check_eq("coll_mode", bus.mode, 2'd1);

        // CHASE: 0001 two cycles after the strobe, then rotate every 12 edges.
        bus.mode_sel  = 2'd2;
        bus.mode_load = 1'b1;
        clk_step();
        bus.mode_load = 1'b0;
        check_eq("chase_mode", bus.mode, 2'd2);
        for (int k = 1; k <= 30; k++) begin
            clk_step();
            exp_led = 4'b0001 << (((k - 1) / 12) % 4);
            check_eq($sformatf("chase_led_%0d", k), bus.led, exp_led);
            check_eq($sformatf("chase_st_%0d", k), bus.step_tick, (k % 12) == 0);
        end

        // Async reset mid-CHASE (pattern 0100), no clock edge in between.
        #2;
        gsrn = 1'b0;
        #1;
        check_eq("async_led", bus.led, 4'h0);
        check_eq("async_mode", bus.mode, 2'd1);
        check_eq("async_st", bus.step_tick, 1'b0);

        // BLINK at brightness 64 from reset over 768 edges (3 PWM periods, 32 blink periods).
        bus.brightness = 8'd64;
        repeat (2) clk_step();
        gsrn     = 1'b1;
        uneq_cnt = 0;
        for (int b = 0; b < 4; b++) on_cnt[b] = 0;
        for (int n = 1; n <= 768; n++) begin
            clk_step();
            for (int b = 0; b < 4; b++) on_cnt[b] += int'(bus.led[b]);
            if (bus.led != 4'h0 && bus.led != 4'hF) uneq_cnt++;
        end
        for (int b = 0; b < 4; b++) check_eq($sformatf("dim64_on_%0d", b), on_cnt[b], 96);
        check_eq("dim64_uneq", uneq_cnt, 0);

        // Brightness 0 keeps the bank dark.
        bus.brightness = 8'd0;
        repeat (2) clk_step();
        lit_cnt = 0;
        for (int n = 0; n < 256; n++) begin
            clk_step();
            if (bus.led != 4'h0) lit_cnt++;
        end
        check_eq("dim0_lit", lit_cnt, 0);

        // BREATHE (brightness left at 0 to show it is ignored), loads at edges 58 and 250.
        gsrn = 1'b0;
        repeat (2) clk_step();
        gsrn         = 1'b1;
        bus.mode_sel = 2'd3;
        for (int n = 1; n <= 290; n++) begin
            clk_step();
            if (n > 58 && n <= 98) begin
                check_eq($sformatf("breathe_a_%0d", n), bus.led, breathe_exp(n, 58));
            end
            if (n > 250 && n <= 290) begin
                check_eq($sformatf("breathe_b_%0d", n), bus.led, breathe_exp(n, 250));
            end
            if (n == 60) check_eq("breathe_mode", bus.mode, 2'd3);
            bus.mode_load = (n == 57 || n == 249);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
